// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised FIFO family: default sizes,
// read-mode encoding and a small log2 helper.
package fifo_pkg;

    localparam int FIFO_DEFAULT_WIDTH      = 8;
    localparam int FIFO_DEFAULT_ADDR_WIDTH = 3;

    typedef enum logic {
        FIFO_MODE_STD  = 1'b0,
        FIFO_MODE_FWFT = 1'b1
    } fifo_mode_e;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port RAM, DEPTH x WIDTH, with one synchronous write port and one
// read port that is registered in standard mode and combinational in FWFT mode.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int WIDTH      = FIFO_DEFAULT_WIDTH,
    parameter int ADDR_WIDTH = FIFO_DEFAULT_ADDR_WIDTH,
    parameter int FWFT       = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    localparam int DEPTH   = 1 << ADDR_WIDTH;
    localparam bit IS_FWFT = (FWFT == int'(FIFO_MODE_FWFT));

    logic [WIDTH-1:0] ram [DEPTH];
    logic [WIDTH-1:0] rd_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            ram[wr_addr] <= wr_data;
        end
    end

    // Read register samples the pre-edge word, so a same-slot write returns the old data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_q <= '0;
        end else if (clear) begin
            rd_q <= '0;
        end else if (rd_en) begin
            rd_q <= ram[rd_addr];
        end
    end

    assign rd_data = IS_FWFT ? ram[rd_addr] : rd_q;

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with optional first-word-fall-through,
// almost-full/almost-empty thresholds, synchronous flush and sticky error flags.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH         = FIFO_DEFAULT_WIDTH,
    parameter int ADDR_WIDTH    = FIFO_DEFAULT_ADDR_WIDTH,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 1,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic [WIDTH-1:0]      data_in,
    input  logic                  put,
    input  logic                  get,
    output logic [WIDTH-1:0]      data_out,
    output logic                  valid,
    output logic [ADDR_WIDTH:0]   fillcount,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int PTR_W   = ADDR_WIDTH + 1;
    localparam int DEPTH   = 1 << ADDR_WIDTH;
    localparam bit IS_FWFT = (FWFT == int'(FIFO_MODE_FWFT));

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] count;
    logic [PTR_W-1:0] next_count;
    logic             rd_ok;
    logic             wr_ok;
    logic             empty_q;
    logic             full_q;
    logic             aempty_q;
    logic             afull_q;
    logic             valid_q;
    logic             overflow_q;
    logic             underflow_q;

    assign count = wr_ptr - rd_ptr;

    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    assign rd_ok      = get & ~empty_q;
    assign wr_ok      = put & (~full_q | rd_ok);
    assign next_count = count + PTR_W'(wr_ok) - PTR_W'(rd_ok);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            aempty_q    <= 1'b1;
            afull_q     <= (AFULL_THRESH == 0);
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (clear) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            aempty_q    <= 1'b1;
            afull_q     <= (AFULL_THRESH == 0);
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            empty_q     <= (next_count == '0);
            full_q      <= (next_count == PTR_W'(DEPTH));
            aempty_q    <= (int'(next_count) <= AEMPTY_THRESH);
            afull_q     <= (int'(next_count) >= AFULL_THRESH);
            valid_q     <= rd_ok;
            overflow_q  <= overflow_q | (put & full_q & ~rd_ok);
            underflow_q <= underflow_q | (get & empty_q);
        end
    end

    fifo_mem #(
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .FWFT       (FWFT)
    ) u_mem (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .wr_en   (wr_ok & ~clear),
        .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
        .wr_data (data_in),
        .rd_en   (rd_ok & ~clear),
        .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
        .rd_data (data_out)
    );

    assign fillcount    = count;
    assign empty        = empty_q;
    assign full         = full_q;
    assign almost_empty = aempty_q;
    assign almost_full  = afull_q;
    assign valid        = IS_FWFT ? ~empty_q : valid_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Drives a standard-mode and an FWFT-mode FIFO with the same stimulus and
// compares both against a queue-based model of the FIFO rules.
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       clear;
    logic [7:0] data_in;
    logic       put;
    logic       get;

    logic [7:0] std_data;
    logic       std_valid;
    logic [3:0] std_count;
    logic       std_empty, std_full, std_aempty, std_afull, std_over, std_under;

    logic [7:0] ft_data;
    logic       ft_valid;
    logic [3:0] ft_count;
    logic       ft_empty, ft_full, ft_aempty, ft_afull, ft_over, ft_under;

    logic [7:0] modelQ[$];
    logic [7:0] modelData;
    logic       modelValid;
    logic       modelOver;
    logic       modelUnder;

    int checkCount = 0;
    int failCount  = 0;

    always #5 clk = ~clk;

    sync_fifo_param #(.FWFT(0)) u_std (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear        (clear),
        .data_in      (data_in),
        .put          (put),
        .get          (get),
        .data_out     (std_data),
        .valid        (std_valid),
        .fillcount    (std_count),
        .empty        (std_empty),
        .full         (std_full),
        .almost_empty (std_aempty),
        .almost_full  (std_afull),
        .overflow     (std_over),
        .underflow    (std_under)
    );

    sync_fifo_param #(.FWFT(1)) u_fwft (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear        (clear),
        .data_in      (data_in),
        .put          (put),
        .get          (get),
        .data_out     (ft_data),
        .valid        (ft_valid),
        .fillcount    (ft_count),
        .empty        (ft_empty),
        .full         (ft_full),
        .almost_empty (ft_aempty),
        .almost_full  (ft_afull),
        .overflow     (ft_over),
        .underflow    (ft_under)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        modelQ.delete();
        modelData  = 8'h00;
        modelValid = 1'b0;
        modelOver  = 1'b0;
        modelUnder = 1'b0;
    endtask

    // One clock edge of the FIFO rules, evaluated on the pre-edge occupancy.
    task automatic modelStep(input logic p, input logic g, input logic c, input logic [7:0] d);
        int  size;
        bit  rdOk;
        bit  wrOk;
        size = modelQ.size();
        if (c) begin
            modelReset();
        end else begin
            rdOk = g && (size > 0);
            wrOk = p && ((size < 8) || rdOk);
            if (g && size == 0) modelUnder = 1'b1;
            if (p && size == 8 && !rdOk) modelOver = 1'b1;
            if (rdOk) begin
                modelData  = modelQ.pop_front();
                modelValid = 1'b1;
            end else begin
                modelValid = 1'b0;
            end
            if (wrOk) modelQ.push_back(d);
        end
    endtask

    task automatic checkAll();
        int size;
        size = modelQ.size();
        checkOutput("std fillcount", 32'(std_count), 32'(size));
        checkOutput("std empty", 32'(std_empty), 32'(size == 0));
        checkOutput("std full", 32'(std_full), 32'(size == 8));
        checkOutput("std almost_empty", 32'(std_aempty), 32'(size <= 1));
        checkOutput("std almost_full", 32'(std_afull), 32'(size >= 7));
        checkOutput("std overflow", 32'(std_over), 32'(modelOver));
        checkOutput("std underflow", 32'(std_under), 32'(modelUnder));
        checkOutput("std valid", 32'(std_valid), 32'(modelValid));
        checkOutput("std data_out", 32'(std_data), 32'(modelData));
        checkOutput("fwft fillcount", 32'(ft_count), 32'(size));
        checkOutput("fwft valid", 32'(ft_valid), 32'(size > 0));
        checkOutput("fwft overflow", 32'(ft_over), 32'(modelOver));
        checkOutput("fwft underflow", 32'(ft_under), 32'(modelUnder));
        if (size > 0) begin
            checkOutput("fwft data_out", 32'(ft_data), 32'(modelQ[0]));
        end
    endtask

    // Inputs change on the falling edge; outputs are checked on the next falling edge.
    task automatic applyStimulus(input logic p, input logic g, input logic c, input logic [7:0] d);
        put     = p;
        get     = g;
        clear   = c;
        data_in = d;
        @(posedge clk);
        modelStep(p, g, c, d);
        @(negedge clk);
        put   = 1'b0;
        get   = 1'b0;
        clear = 1'b0;
        checkAll();
    endtask

    initial begin
        reset_n = 1'b0;
        clear   = 1'b0;
        put     = 1'b0;
        get     = 1'b0;
        data_in = 8'h00;
        modelReset();
        repeat (2) @(negedge clk);
        checkAll();
        reset_n = 1'b1;
        @(negedge clk);

        // Fill with 0x01..0x08, one extra put to overflow, then drain in order.
        for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'(i));
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h99);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);

        // Put+get on empty: put wins, get is rejected and flags underflow.
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h3C);
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h77);

        // Flush with count 6 and overflow set while put and get are also asserted.
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h88);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'hEE);

        // FWFT head word becomes visible without a get, then pops.
        applyStimulus(1'b1, 1'b0, 1'b0, 8'hA5);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);

        // Hold occupancy at 3 while the pointers wrap several times.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'(8'hB0 + i));
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b1, 1'b0, 8'(8'hC0 + i));

        // Asynchronous reset with five words stored.
        applyStimulus(1'b1, 1'b0, 1'b0, 8'hD1);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'hD2);
        reset_n = 1'b0;
        #1;
        modelReset();
        checkAll();
        @(negedge clk);
        reset_n = 1'b1;

        // Random traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45),
                          1'($urandom_range(0, 63) == 0), 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
